// File: rtl/arm_immed_encoder.sv
// Iterative search for the ARM rotated-immediate encoding of a 32-bit constant,
// checking LANES even rotations per cycle and optionally retrying with ~value.
module arm_immed_encoder #(
    parameter int LANES        = 1,
    parameter bit ALLOW_INVERT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] value,
    input  logic        try_invert,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [11:0] encoded,
    output logic        found,
    output logic        inverted
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state;
    logic [31:0] val_q;
    logic        inv_en;
    logic        phase_inv;
    logic [3:0]  rot;

    logic        accept;
    logic [31:0] src;
    logic [31:0] cand;
    logic [3:0]  lane_rot;
    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic        last_group;

    // ROL by 2*r; the upper half of the doubled word handles r == 0 cleanly.
    function automatic logic [31:0] rol_even(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] w;
        w = {v, v} << {r, 1'b0};
        return w[63:32];
    endfunction

    assign accept = (state == IDLE) && start_valid && start_ready;

    // Scan lanes from high to low so the lowest hitting rotation is kept.
    always_comb begin
        src      = phase_inv ? ~val_q : val_q;
        cand     = '0;
        lane_rot = '0;
        hit      = 1'b0;
        hit_rot  = '0;
        hit_imm  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_rot = rot + 4'(l);
            cand     = rol_even(src, lane_rot);
            if (cand[31:8] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = lane_rot;
                hit_imm = cand[7:0];
            end
        end
        last_group = ({1'b0, rot} + 5'(LANES)) >= 5'd16;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            encoded     <= '0;
            found       <= 1'b0;
            inverted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        start_ready <= 1'b0;
                        state       <= SEARCH;
                    end else begin
                        start_ready <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        encoded    <= {hit_rot, hit_imm};
                        found      <= 1'b1;
                        inverted   <= phase_inv;
                    end else if (last_group && !(!phase_inv && inv_en)) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        encoded    <= '0;
                        found      <= 1'b0;
                        inverted   <= 1'b0;
                    end
                end
                DONE: begin
                    // start_ready is re-raised one cycle after returning to IDLE.
                    if (done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            val_q     <= value;
            inv_en    <= try_invert & ALLOW_INVERT;
            rot       <= '0;
            phase_inv <= 1'b0;
        end else if (state == SEARCH && !hit) begin
            if (!last_group) begin
                rot <= rot + 4'(LANES);
            end else if (!phase_inv && inv_en) begin
                phase_inv <= 1'b1;
                rot       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_arm_immed_encoder.sv
// Scoreboard bench for arm_immed_encoder: a LANES=1 instance under directed and
// random traffic, plus a LANES=4 instance for the wide-search cases.
module tb_arm_immed_encoder;

    localparam bit ALLOW_INVERT = 1;

    typedef struct packed {
        logic [31:0] v;
        logic [11:0] enc;
        logic        fnd;
        logic        inv;
        logic [31:0] lat;
        logic [31:0] acc;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid, start_ready, try_invert, done_valid, done_ready;
    logic [31:0] value;
    logic [11:0] encoded;
    logic        found, inverted;

    logic        v4_valid, v4_ready, v4_ti, v4_done, v4_dready;
    logic [31:0] v4_value;
    logic [11:0] v4_enc;
    logic        v4_found, v4_inv;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   force_hold = -1;
    req_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm_immed_encoder #(.LANES(1), .ALLOW_INVERT(ALLOW_INVERT)) u_dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .value(value), .try_invert(try_invert), .done_valid(done_valid),
        .done_ready(done_ready), .encoded(encoded), .found(found), .inverted(inverted)
    );

    arm_immed_encoder #(.LANES(4), .ALLOW_INVERT(ALLOW_INVERT)) u_dut4 (
        .clk(clk), .rst(rst), .start_valid(v4_valid), .start_ready(v4_ready),
        .value(v4_value), .try_invert(v4_ti), .done_valid(v4_done),
        .done_ready(v4_dready), .encoded(v4_enc), .found(v4_found), .inverted(v4_inv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Rotate right, the barrel_shifter IMMED direction.
    function automatic logic [31:0] ror_ref(input logic [31:0] x, input int amt);
        logic [63:0] w;
        w = {x, x} >> amt;
        return w[31:0];
    endfunction

    // Exhaustive search over every (rotate, immed_8) pair, normal phase first.
    function automatic req_t model(input logic [31:0] v, input logic ti, input int lanes);
        req_t        e;
        int          n;
        logic [31:0] tgt;
        n     = 16 / lanes;
        e.v   = v;
        e.enc = '0;
        e.fnd = 1'b0;
        e.inv = 1'b0;
        e.acc = '0;
        e.lat = (ti && ALLOW_INVERT) ? 32'(2 * n) : 32'(n);
        for (int ph = 0; ph < 2; ph++) begin
            if (!e.fnd && (ph == 0 || (ti && ALLOW_INVERT))) begin
                tgt = (ph == 1) ? ~v : v;
                for (int r = 0; r < 16; r++)
                    for (int i = 0; i < 256; i++)
                        if (!e.fnd && ror_ref(32'(i), 2 * r) == tgt) begin
                            e.fnd = 1'b1;
                            e.enc = {4'(r), 8'(i)};
                            e.inv = (ph == 1);
                            e.lat = 32'(ph * n + r / lanes + 1);
                        end
            end
        end
        return e;
    endfunction

    function automatic req_t mk(input logic [31:0] v, input logic [11:0] enc,
                                input logic fnd, input logic inv, input int lat);
        req_t e;
        e.v = v; e.enc = enc; e.fnd = fnd; e.inv = inv; e.lat = 32'(lat); e.acc = '0;
        return e;
    endfunction

    function automatic logic [31:0] rand_value();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = ror_ref(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            2: v = ~ror_ref(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            default: v = $urandom & 32'h0000_03FF;
        endcase
        return v;
    endfunction

    task automatic issue(input req_t e, input logic ti, input bit push);
        int   w;
        req_t x;
        x = e;
        w = 0;
        @(negedge clk);
        start_valid = 1'b1;
        value       = e.v;
        try_invert  = ti;
        while (!start_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) begin
            timeout_fail("start_ready_wait");
            start_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        x.acc = 32'(cyc);
        if (push) q.push_back(x);
        start_valid = 1'b0;
        value       = $urandom;
        try_invert  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || done_valid || !start_ready) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 300) timeout_fail("drain");
    endtask

    task automatic run4(input req_t e, input logic ti);
        int w;
        int acc;
        @(negedge clk);
        v4_valid = 1'b1;
        v4_value = e.v;
        v4_ti    = ti;
        w = 0;
        while (!v4_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        v4_valid = 1'b0;
        v4_value = $urandom;
        w = 0;
        while (!v4_done && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!v4_done) begin
            timeout_fail("l4_done_wait");
        end else begin
            chk("l4_encoded", 32'(v4_enc), 32'(e.enc));
            chk("l4_found", 32'(v4_found), 32'(e.fnd));
            chk("l4_inverted", 32'(v4_inv), 32'(e.inv));
            chk("l4_latency", 32'(cyc - acc), e.lat);
            if (v4_found)
                chk("l4_round_trip", ror_ref(32'(v4_enc[7:0]), 2 * int'(v4_enc[11:8])),
                    v4_inv ? ~e.v : e.v);
        end
        v4_dready = 1'b1;
        @(posedge clk);
        #1;
        v4_dready = 1'b0;
        chk("l4_release_done_valid", 32'(v4_done), 32'd0);
    endtask

    // Monitor: compares each result against the scoreboard and drives done_ready.
    initial begin
        req_t        e;
        int          hold;
        logic [11:0] enc0;
        logic        f0, i0;
        done_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_valid === 1'b1) begin
                enc0 = encoded;
                f0   = found;
                i0   = inverted;
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_valid actual 1 required 0");
                end else begin
                    e = q.pop_front();
                    chk("encoded", 32'(encoded), 32'(e.enc));
                    chk("found", 32'(found), 32'(e.fnd));
                    chk("inverted", 32'(inverted), 32'(e.inv));
                    chk("latency", 32'(cyc) - e.acc, e.lat);
                    if (found)
                        chk("round_trip", ror_ref(32'(encoded[7:0]), 2 * int'(encoded[11:8])),
                            inverted ? ~e.v : e.v);
                end
                hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
                force_hold = -1;
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_done_valid", 32'(done_valid), 32'd1);
                    chk("hold_encoded", 32'(encoded), 32'(enc0));
                    chk("hold_found", 32'(found), 32'(f0));
                    chk("hold_inverted", 32'(inverted), 32'(i0));
                    chk("hold_start_ready", 32'(start_ready), 32'd0);
                end
                done_ready = 1'b1;
                @(posedge clk);
                #1;
                done_ready = 1'b0;
                chk("release_done_valid", 32'(done_valid), 32'd0);
                chk("release_start_ready", 32'(start_ready), 32'd0);
                @(posedge clk);
                #1;
                chk("idle_start_ready", 32'(start_ready), 32'd1);
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic        ti;
        start_valid = 1'b0; value = '0; try_invert = 1'b0;
        v4_valid = 1'b0; v4_value = '0; v4_ti = 1'b0; v4_dready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_start_ready", 32'(start_ready), 32'd1);
        chk("reset_done_valid", 32'(done_valid), 32'd0);
        chk("reset_encoded", 32'(encoded), 32'd0);
        chk("reset_found", 32'(found), 32'd0);
        chk("reset_inverted", 32'(inverted), 32'd0);
        chk("reset_l4_start_ready", 32'(v4_ready), 32'd1);

        issue(mk(32'h0000_00AB, 12'h0AB, 1'b1, 1'b0, 1), 1'b0, 1'b1);
        issue(mk(32'hF000_000F, 12'h2FF, 1'b1, 1'b0, 3), 1'b0, 1'b1);
        issue(mk(32'h0000_0104, 12'hF41, 1'b1, 1'b0, 16), 1'b0, 1'b1);
        issue(mk(32'hFFFF_FF00, 12'h0FF, 1'b1, 1'b1, 17), 1'b1, 1'b1);
        issue(mk(32'hFFFF_FF00, 12'h000, 1'b0, 1'b0, 16), 1'b0, 1'b1);
        issue(mk(32'h0000_0000, 12'h000, 1'b1, 1'b0, 1), 1'b1, 1'b1);
        issue(mk(32'h0000_00FF, 12'h0FF, 1'b1, 1'b0, 1), 1'b1, 1'b1);

        drain();
        force_hold = 5;
        issue(mk(32'h0000_0102, 12'h000, 1'b0, 1'b0, 32), 1'b1, 1'b1);
        drain();

        // Abandoned request: reset lands on the fifth search cycle.
        issue(mk(32'h0000_0102, 12'h000, 1'b0, 1'b0, 32), 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_done_valid", 32'(done_valid), 32'd0);
        chk("abort_encoded", 32'(encoded), 32'd0);
        chk("abort_found", 32'(found), 32'd0);
        repeat (40) @(posedge clk);
        issue(mk(32'hF000_000F, 12'h2FF, 1'b1, 1'b0, 3), 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            v  = rand_value();
            ti = 1'($urandom_range(0, 1));
            issue(model(v, ti, 1), ti, 1'b1);
        end
        drain();

        run4(mk(32'h0000_0104, 12'hF41, 1'b1, 1'b0, 4), 1'b0);
        run4(mk(32'hF000_000F, 12'h2FF, 1'b1, 1'b0, 1), 1'b0);
        run4(mk(32'hFFFF_FF00, 12'h0FF, 1'b1, 1'b1, 5), 1'b1);
        run4(mk(32'h0000_0102, 12'h000, 1'b0, 1'b0, 8), 1'b1);
        for (int i = 0; i < 100; i++) begin
            v  = rand_value();
            ti = 1'($urandom_range(0, 1));
            run4(model(v, ti, 4), ti);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
